// File: rtl/rhd_cmd_pkg.sv
// rtl/rhd_cmd_pkg.sv - RHD2132 command encodings, tag kinds, scheduler states and register-init table
package rhd_cmd_pkg;

    localparam int N_CH        = 32;
    localparam int N_TRAIL     = 3;
    localparam int N_INIT      = 18;
    localparam int N_CAL_DUMMY = 9;

    localparam logic [1:0] KIND_CONV  = 2'b00;
    localparam logic [1:0] KIND_AUX   = 2'b01;
    localparam logic [1:0] KIND_WRITE = 2'b10;
    localparam logic [1:0] KIND_CAL   = 2'b11;

    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [15:0] CMD_DUMMY     = 16'hE800;

    // State names the source of the next word to load, not the word on the bus.
    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_CAL,
        ST_CAL_DUMMY,
        ST_IDLE,
        ST_CONV,
        ST_TRAIL
    } state_e;

    function automatic logic [15:0] enc_convert(input logic [5:0] ch);
        return {2'b00, ch, 8'h00};
    endfunction

    function automatic logic [15:0] enc_write(input logic [5:0] reg_addr, input logic [7:0] reg_data);
        return {2'b10, reg_addr, reg_data};
    endfunction

    function automatic logic [7:0] make_tag(input logic [1:0] kind, input logic [5:0] idx);
        return {kind, idx};
    endfunction

    function automatic logic [7:0] init_reg_data(input logic [5:0] reg_addr);
        logic [7:0] val;
        case (reg_addr)
            6'd0:    val = 8'hDE;
            6'd1:    val = 8'h42;
            6'd2:    val = 8'h04;
            6'd3:    val = 8'h02;
            6'd4:    val = 8'h96;
            6'd8:    val = 8'h16;
            6'd9:    val = 8'h17;
            6'd10:   val = 8'hA8;
            6'd12:   val = 8'h2C;
            6'd13:   val = 8'h86;
            6'd14:   val = 8'hFF;
            6'd15:   val = 8'hFF;
            6'd16:   val = 8'hFF;
            6'd17:   val = 8'hFF;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/rhd_cmd_scheduler_if.sv
// rtl/rhd_cmd_scheduler_if.sv - command word stream and SPI result tag channel
interface rhd_cmd_scheduler_if;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_tag;
    logic        rsp_tag_valid;

    modport master (
        output cmd_data, cmd_valid, rsp_tag, rsp_tag_valid,
        input  cmd_ready, rsp_valid
    );

    modport slave (
        input  cmd_data, cmd_valid, rsp_tag, rsp_tag_valid,
        output cmd_ready, rsp_valid
    );
endinterface

// File: rtl/rhd_rsp_tag_pipe.sv
// rtl/rhd_rsp_tag_pipe.sv - 3-deep shift register of issued command tags; a result belongs to the command two accepts back
module rhd_rsp_tag_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_tag,
    input  logic       rsp_valid,
    output logic [7:0] rsp_tag,
    output logic       rsp_tag_valid
);

    logic [2:0]      vld_q, vld_d;
    logic [2:0][7:0] tag_q, tag_d;

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (push) begin
            vld_d = {vld_q[1:0], 1'b1};
            tag_d = {tag_q[1:0], push_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    // Lookup reads pre-shift contents, so a same-cycle push does not disturb it.
    assign rsp_tag_valid = rsp_valid & vld_q[2];
    assign rsp_tag       = rsp_valid ? tag_q[2] : 8'h00;

endmodule

// File: rtl/rhd_cmd_scheduler.sv
// rtl/rhd_cmd_scheduler.sv - RHD2132 command sequencer: init writes, calibration, sample frames, host writes
// Optional RHD_AUX_CMD_EN: trailer slots become CONVERT(32..34) aux reads instead of dummies.
module rhd_cmd_scheduler
    import rhd_cmd_pkg::*;
(
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  adc_en,
    rhd_cmd_scheduler_if.master   cmd_if,
    output logic                  frame_start,
    input  logic                  host_wr_req,
    input  logic [5:0]            host_wr_addr,
    input  logic [7:0]            host_wr_data,
    output logic                  host_wr_ack,
    output logic                  init_done
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic [7:0]  cmd_tag_q, cmd_tag_d;
    logic        cmd_host_q, cmd_host_d;
    logic        cmd_last_cal_q, cmd_last_cal_d;
    logic        init_done_q, init_done_d;

    logic accept;
    logic load;
    logic host_req_eff;

    assign accept = cmd_valid_q & cmd_if.cmd_ready;
    assign load   = ~cmd_valid_q | cmd_if.cmd_ready;
    // A host word already on the bus must not be issued twice while the request is still high.
    assign host_req_eff = host_wr_req & ~(cmd_valid_q & cmd_host_q);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_data_d     = cmd_data_q;
        cmd_tag_d      = cmd_tag_q;
        cmd_host_d     = cmd_host_q;
        cmd_last_cal_d = cmd_last_cal_q;
        init_done_d    = init_done_q | (accept & cmd_last_cal_q);

        if (load) begin
            cmd_valid_d    = 1'b1;
            cmd_host_d     = 1'b0;
            cmd_last_cal_d = 1'b0;
            case (state_q)
                ST_INIT_WR: begin
                    cmd_data_d = enc_write(cnt_q, init_reg_data(cnt_q));
                    cmd_tag_d  = make_tag(KIND_WRITE, cnt_q);
                    if (cnt_q == 6'(N_INIT - 1)) begin
                        state_d = ST_CAL;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_CAL: begin
                    cmd_data_d = CMD_CALIBRATE;
                    cmd_tag_d  = make_tag(KIND_CAL, 6'd0);
                    state_d    = ST_CAL_DUMMY;
                    cnt_d      = 6'd0;
                end
                ST_CAL_DUMMY: begin
                    cmd_data_d = CMD_DUMMY;
                    cmd_tag_d  = make_tag(KIND_CAL, cnt_q);
                    if (cnt_q == 6'(N_CAL_DUMMY - 1)) begin
                        cmd_last_cal_d = 1'b1;
                        state_d        = ST_IDLE;
                        cnt_d          = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_IDLE: begin
                    // Frame boundary decision: host write wins over a new frame.
                    if (host_req_eff) begin
                        cmd_data_d = enc_write(host_wr_addr, host_wr_data);
                        cmd_tag_d  = make_tag(KIND_WRITE, host_wr_addr);
                        cmd_host_d = 1'b1;
                    end else if (adc_en) begin
                        cmd_data_d = enc_convert(6'd0);
                        cmd_tag_d  = make_tag(KIND_CONV, 6'd0);
                        state_d    = ST_CONV;
                        cnt_d      = 6'd1;
                    end else begin
                        cmd_valid_d = 1'b0;
                    end
                end
                ST_CONV: begin
                    cmd_data_d = enc_convert(cnt_q);
                    cmd_tag_d  = make_tag(KIND_CONV, cnt_q);
                    if (cnt_q == 6'(N_CH - 1)) begin
                        state_d = ST_TRAIL;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_TRAIL: begin
`ifdef RHD_AUX_CMD_EN
                    cmd_data_d = enc_convert(6'(N_CH) + cnt_q);
                    cmd_tag_d  = make_tag(KIND_AUX, 6'(N_CH) + cnt_q);
`else
                    cmd_data_d = CMD_DUMMY;
                    cmd_tag_d  = make_tag(KIND_CAL, 6'(N_CH) + cnt_q);
`endif
                    if (cnt_q == 6'(N_TRAIL - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_INIT_WR;
                    cnt_d       = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q        <= ST_INIT_WR;
            cnt_q          <= 6'd0;
            cmd_valid_q    <= 1'b0;
            cmd_data_q     <= 16'h0000;
            cmd_tag_q      <= 8'h00;
            cmd_host_q     <= 1'b0;
            cmd_last_cal_q <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_data_q     <= cmd_data_d;
            cmd_tag_q      <= cmd_tag_d;
            cmd_host_q     <= cmd_host_d;
            cmd_last_cal_q <= cmd_last_cal_d;
            init_done_q    <= init_done_d;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_data  = cmd_data_q;
    assign frame_start      = accept & (cmd_tag_q == make_tag(KIND_CONV, 6'd0));
    assign host_wr_ack      = accept & cmd_host_q;
    assign init_done        = init_done_q;

    rhd_rsp_tag_pipe u_tag_pipe (
        .clk           (sysclk),
        .rst           (rst),
        .push          (accept),
        .push_tag      (cmd_tag_q),
        .rsp_valid     (cmd_if.rsp_valid),
        .rsp_tag       (cmd_if.rsp_tag),
        .rsp_tag_valid (cmd_if.rsp_tag_valid)
    );

endmodule
